// File: rtl/qspi_cmd_master_if.sv
// ---------------------------------------------------------------------------
// qspi_cmd_master_if
// Requester-side bundle for qspi_cmd_master.
//   req_*        : transaction request (valid/ready handshake)
//   wdata_*      : write word stream, one word per valid/ready handshake
//   rdata_*      : read word stream, single-cycle pulse, no backpressure
//   busy / err   : transaction in progress / sticky timeout flag
// Modports:
//   master : the on-chip requester (boot loader, debug bridge, testbench)
//   slave  : the qspi_cmd_master engine
// ---------------------------------------------------------------------------
interface qspi_cmd_master_if #(
    parameter int LW = 9
);
    logic          req_valid;
    logic          req_ready;
    logic [7:0]    req_cmd;
    logic [31:0]   req_addr;
    logic          req_has_addr;
    logic          req_rnw;
    logic [LW-1:0] req_len;
    logic [5:0]    req_dummy;
    logic          req_quad;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [31:0]   wdata;
    logic          rdata_valid;
    logic [31:0]   rdata;
    logic          busy;
    logic          err;

    modport master (
        output req_valid, req_cmd, req_addr, req_has_addr, req_rnw,
               req_len, req_dummy, req_quad, wdata_valid, wdata,
        input  req_ready, wdata_ready, rdata_valid, rdata, busy, err
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_has_addr, req_rnw,
               req_len, req_dummy, req_quad, wdata_valid, wdata,
        output req_ready, wdata_ready, rdata_valid, rdata, busy, err
    );
endinterface

// File: rtl/qspi_cmd_master.sv
// ---------------------------------------------------------------------------
// qspi_cmd_master
// SPI / QPI (mode 0) master issuing cmd / addr / dummy / data transactions
// to a PULPino-style SPI slave.
// Ports:
//   clk, rst_n     : system clock, asynchronous active-low reset
//   bus (slave)    : request, write-word, read-word streams, busy, err
//   spi_clk_o      : SCK, idles low
//   spi_csn_o      : chip select, active low
//   spi_mode_o     : pad direction, 00 single, 10 quad tx, 01 quad rx
//   spi_sdo_o      : serial data out (lane 0 only in single mode)
//   spi_sdi_i      : serial data in  (lane 0 only in single mode)
// Optional feature macro: QSPI_CMD_MASTER_TIMEOUT_EN
//   When defined, a write pause longer than TIMEOUT cycles aborts the
//   transaction and sets the sticky err flag. When undefined, err is 0.
// ---------------------------------------------------------------------------
module qspi_cmd_master #(
    parameter int CLK_DIV = 2,
    parameter int CS_IDLE = 4,
    parameter int MAX_LEN = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    qspi_cmd_master_if.slave bus,
    output logic             spi_clk_o,
    output logic             spi_csn_o,
    output logic [1:0]       spi_mode_o,
    output logic [3:0]       spi_sdo_o,
    input  logic [3:0]       spi_sdi_i
);
    localparam int LW = $clog2(MAX_LEN + 1);
    // One counter serves both the csn gap and the write-pause timeout.
    localparam int CW = $clog2(((CS_IDLE > TIMEOUT) ? CS_IDLE : TIMEOUT) + 1);
    localparam logic [7:0]    DIV_M1  = 8'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_M1  = CW'(CS_IDLE - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
`ifdef QSPI_CMD_MASTER_TIMEOUT_EN
    localparam logic [CW-1:0] TO_M1   = CW'(TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, HOLD, GAP} state_t;

    state_t        state, nxt, data_phase;
    logic [7:0]    div_cnt;
    logic [5:0]    bit_cnt;
    logic [CW-1:0] wait_cnt;
    logic [LW-1:0] len_r, words_left, len_clamp;
    logic [31:0]   addr_r, sh, rsh, sh_shift, rsh_next;
    logic [5:0]    dummy_r, word_bits;
    logic          has_addr_r, rnw_r, quad_r, loaded;
    logic          sck_evt, rise_evt, fall_evt, last_bit, load_now;

    function automatic logic [3:0] out_bits(input logic [31:0] s, input logic q);
        return q ? s[31:28] : {3'b000, s[31]};
    endfunction

    function automatic logic [1:0] mode_for(input state_t s, input logic q);
        if (!q) return 2'b00;
        if ((s == CMD) || (s == ADDR) || (s == WDATA)) return 2'b10;
        if ((s == DUMMY) || (s == RDATA)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        word_bits = quad_r ? 6'd8 : 6'd32;
        sh_shift  = quad_r ? {sh[27:0], 4'h0} : {sh[30:0], 1'b0};
        rsh_next  = quad_r ? {rsh[27:0], spi_sdi_i} : {rsh[30:0], spi_sdi_i[0]};
        len_clamp = (bus.req_len > LEN_MAX) ? LEN_MAX : bus.req_len;
        // SCK only runs in shifting states; a write word not yet loaded freezes it low.
        sck_evt = 1'b0;
        if ((state == CMD) || (state == ADDR) || (state == DUMMY) || (state == RDATA) ||
            ((state == WDATA) && loaded))
            sck_evt = (div_cnt == DIV_M1);
        rise_evt = sck_evt && !spi_clk_o;
        fall_evt = sck_evt && spi_clk_o;
        last_bit = (bit_cnt == 6'd1);
        if (len_r == '0)            data_phase = HOLD;
        else if (!rnw_r)            data_phase = WDATA;
        else if (dummy_r != 6'd0)   data_phase = DUMMY;
        else                        data_phase = RDATA;
        nxt = HOLD;
        case (state)
            CMD:          nxt = has_addr_r ? ADDR : data_phase;
            ADDR:         nxt = data_phase;
            DUMMY:        nxt = RDATA;
            RDATA, WDATA: nxt = (words_left == LW'(1)) ? HOLD : state;
            default:      nxt = HOLD;
        endcase
        // A write word is taken either on the falling edge that closes the
        // previous phase/word (no SCK stretch) or later, ending a pause.
        load_now = bus.wdata_valid &&
                   (((state == WDATA) && !loaded) || (fall_evt && last_bit && (nxt == WDATA)));
    end

    assign bus.wdata_ready = load_now;

`ifndef QSPI_CMD_MASTER_TIMEOUT_EN
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.req_ready   <= 1'b1;
            bus.busy        <= 1'b0;
            bus.rdata_valid <= 1'b0;
            bus.rdata       <= '0;
`ifdef QSPI_CMD_MASTER_TIMEOUT_EN
            bus.err         <= 1'b0;
`endif
            spi_clk_o  <= 1'b0;
            spi_csn_o  <= 1'b1;
            spi_mode_o <= 2'b00;
            spi_sdo_o  <= 4'h0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            len_r      <= '0;
            words_left <= '0;
            addr_r     <= '0;
            dummy_r    <= '0;
            has_addr_r <= 1'b0;
            rnw_r      <= 1'b0;
            quad_r     <= 1'b0;
            loaded     <= 1'b0;
            sh         <= '0;
            rsh        <= '0;
        end else begin
            bus.rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state         <= CMD;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
`ifdef QSPI_CMD_MASTER_TIMEOUT_EN
                        bus.err       <= 1'b0;
`endif
                        addr_r     <= bus.req_addr;
                        has_addr_r <= bus.req_has_addr;
                        rnw_r      <= bus.req_rnw;
                        dummy_r    <= bus.req_dummy;
                        quad_r     <= bus.req_quad;
                        len_r      <= len_clamp;
                        words_left <= len_clamp;
                        // First command bit is on sdo as csn falls.
                        sh         <= {bus.req_cmd, 24'h0};
                        spi_sdo_o  <= out_bits({bus.req_cmd, 24'h0}, bus.req_quad);
                        spi_mode_o <= bus.req_quad ? 2'b10 : 2'b00;
                        spi_csn_o  <= 1'b0;
                        bit_cnt    <= bus.req_quad ? 6'd2 : 6'd8;
                        div_cnt    <= '0;
                    end
                end
                CMD, ADDR, DUMMY, WDATA, RDATA: begin
                    if ((state == WDATA) && !loaded) begin
                        // Write pause: SCK held low until a word arrives.
                        if (bus.wdata_valid) begin
                            sh        <= bus.wdata;
                            spi_sdo_o <= out_bits(bus.wdata, quad_r);
                            loaded    <= 1'b1;
                            bit_cnt   <= word_bits;
                            div_cnt   <= '0;
                        end
`ifdef QSPI_CMD_MASTER_TIMEOUT_EN
                        else if (wait_cnt == TO_M1) begin
                            state      <= HOLD;
                            bus.err    <= 1'b1;
                            div_cnt    <= '0;
                            spi_mode_o <= 2'b00;
                            spi_sdo_o  <= 4'h0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
`endif
                    end else if (sck_evt) begin
                        div_cnt   <= '0;
                        spi_clk_o <= ~spi_clk_o;
                        if (rise_evt) begin
                            rsh <= rsh_next;
                            if ((state == RDATA) && last_bit) begin
                                bus.rdata       <= rsh_next;
                                bus.rdata_valid <= 1'b1;
                            end
                        end else if (!last_bit) begin
                            bit_cnt   <= bit_cnt - 6'd1;
                            sh        <= sh_shift;
                            spi_sdo_o <= out_bits(sh_shift, quad_r);
                        end else begin
                            // Falling edge after the last bit of a phase or word.
                            if ((state == RDATA) || (state == WDATA))
                                words_left <= words_left - LW'(1);
                            state      <= nxt;
                            spi_mode_o <= mode_for(nxt, quad_r);
                            loaded     <= 1'b0;
                            wait_cnt   <= '0;
                            spi_sdo_o  <= 4'h0;
                            case (nxt)
                                ADDR: begin
                                    sh        <= addr_r;
                                    spi_sdo_o <= out_bits(addr_r, quad_r);
                                    bit_cnt   <= word_bits;
                                end
                                DUMMY:   bit_cnt <= dummy_r;
                                RDATA:   bit_cnt <= word_bits;
                                WDATA: begin
                                    if (bus.wdata_valid) begin
                                        sh        <= bus.wdata;
                                        spi_sdo_o <= out_bits(bus.wdata, quad_r);
                                        loaded    <= 1'b1;
                                        bit_cnt   <= word_bits;
                                    end
                                end
                                default: bit_cnt <= '0;
                            endcase
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    // SCK rests low for one half-period before csn rises.
                    if (div_cnt == DIV_M1) begin
                        spi_csn_o <= 1'b1;
                        state     <= GAP;
                        wait_cnt  <= '0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (wait_cnt == GAP_M1) begin
                        state         <= IDLE;
                        bus.req_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/qspi_cmd_master.md
Name: qspi_cmd_master

Overview:
- Synthesizable SPI/QPI master that issues command/address/dummy/data transactions to a PULPino-style SPI slave.
- Single lane uses sdo0/sdi0; quad lane uses sdo0..3/sdi0..3.
- Sits between an on-chip requester (boot loader or debug bridge) and the SPI master pads; hardware counterpart of the bench SPI load/check tasks.
- Mode 0 only: CPOL=0, CPHA=0.

Parameters:
- CLK_DIV, 2: SCK half-period in clk cycles; legal range 1..255.
- CS_IDLE, 4: minimum clk cycles that csn stays high between transactions.
- MAX_LEN, 256: maximum data words per transaction; len field is $clog2(MAX_LEN+1) bits wide.
- TIMEOUT, 1024: stall limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  transaction request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_cmd  in  8  command byte
- req_addr  in  32  address
- req_has_addr  in  1  send address phase
- req_rnw  in  1  1=read data phase, 0=write data phase
- req_len  in  LW  data words; 0 = no data phase
- req_dummy  in  6  dummy SCK cycles, read only
- req_quad  in  1  1=all phases on 4 lanes, 0=single lane
- wdata_valid  in  1  write word available
- wdata_ready  out  1  write word consumed
- wdata  in  32  write word, MSB first
- rdata_valid  out  1  one-cycle pulse, read word complete
- rdata  out  32  read word
- busy  out  1  transaction in progress
- err  out  1  sticky timeout flag (feature only; otherwise tied 0)
- spi_clk_o  out  1  SCK
- spi_csn_o  out  1  chip select, active low
- spi_mode_o  out  2  00=single, 10=quad tx, 01=quad rx; pad direction control
- spi_sdo_o  out  4  serial data out
- spi_sdi_i  in  4  serial data in

Behaviour:
- Reset values: req_ready=1, spi_csn_o=1, spi_clk_o=0, spi_sdo_o=0, spi_mode_o=00, busy=0, wdata_ready=0, rdata_valid=0, rdata=0, err=0.
- FSM states: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, HOLD, GAP.
- IDLE: on request handshake, latch all req_* fields; csn falls on the next cycle; enter CMD. req_ready=0 in every state except IDLE.
- SCK: toggles every CLK_DIV clk cycles. sdo changes on the falling edge (first bit is set up before the first rising edge). sdi is sampled on the rising edge.
- Bit counts per phase:
  - CMD: 8 SCK single / 2 SCK quad.
  - ADDR: 32 single / 8 quad, skipped if has_addr=0.
  - DUMMY: req_dummy SCK; skipped if 0, if write, or if len=0.
  - Data: 32 single / 8 quad SCK per word.
- Bit ordering: MSB first. In quad mode each nibble goes out as sdo[3:0]=bits[n+3:n].
- spi_mode_o: 10 during CMD/ADDR/WDATA in quad mode; 01 from DUMMY start through RDATA in quad mode; 00 in single mode.
- WDATA: the word is loaded from wdata with wdata_ready high for exactly one cycle, only when wdata_valid=1.
  - The load happens before the first bit of each word.
  - If wdata_valid=0 at a word boundary, SCK holds low (pause) and csn stays low until valid.
- RDATA: rdata_valid pulses 1 cycle after the rising edge that samples the word's last bit. No backpressure.
- HOLD: after the last bit, SCK stays low for CLK_DIV cycles, then csn rises.
- GAP: csn stays high for CS_IDLE cycles, then return to IDLE.
- len=0: transaction ends after CMD, or after ADDR if present.
- len is clamped to MAX_LEN.
- Reset mid-transaction: immediate return to reset values; a partial word is discarded.

Optional Feature:
- Macro: QSPI_CMD_MASTER_TIMEOUT_EN.
- With the macro:
  - A counter runs during a write pause.
  - After TIMEOUT cycles without wdata_valid, the transaction aborts: go to HOLD, csn rises, err is set.
  - err clears on the next accepted request.
- Without the macro: pauses are unbounded and err is tied 0.

Test Plan:
- Single write: cmd 0x02, addr 0x0000_0000, len=1, wdata 0xDEADBEEF, CLK_DIV=2 -> 72 SCK; sdo0 serial stream 0x02,0x00000000,0xDEADBEEF; one wdata_ready pulse; csn high after.
- Quad read: cmd 0x0B, addr 0x1A10_7008, dummy=32, len=2, slave returns 0x12345678, 0xCAFEF00D -> 2+8+32+16 SCK; spi_mode_o=01 from DUMMY onward; two rdata_valid pulses with those values.
- Register write, no addr: cmd 0x01, has_addr=0, quad, len=0 -> exactly 2 SCK; csn low for 2*2*CLK_DIV+CLK_DIV cycles; then a GAP of CS_IDLE cycles before req_ready=1.
- Write stall: quad, len=3, wdata_valid withheld 50 cycles before word 2 -> SCK frozen low, csn low, resumes; data intact.
- Timeout (macro on, TIMEOUT=16): withhold wdata 20 cycles -> abort at stall cycle 16; csn=1; err=1; next accepted request clears err.
- Reset mid-RDATA: rst_n low during word 1 -> all outputs at reset values asynchronously; no rdata_valid.
